// File: rtl/twd_mul_pipe.sv
// Purpose: per-lane complex twiddle multiply (fac8 forward/inverse or bypass) with round and saturate.
// Latency: fixed 3 cycles from i_valid to o_valid, one beat per cycle sustained.
// Backpressure: none; the pipeline never stalls and the consumer must accept every output beat.
//
// Ports:
//   clk, rstn            clock and asynchronous active-low reset
//   i_valid, i_mode      input beat qualifier and twiddle set (0 bypass, 1 fwd, 2 inv, 3 = bypass)
//   i_re/i_im[LANES]     signed WIDTH-bit lane samples
//   i_clr_sat            clears the sticky saturation flag
//   o_valid, o_last      output qualifier and final-beat-of-frame marker
//   o_re/o_im[LANES]     signed OUT_WIDTH-bit twiddled lanes (zero when o_valid is low)
//   o_sat                sticky: some output component saturated since the last clear
module twd_mul_pipe #(
    parameter int WIDTH     = 14,
    parameter int OUT_WIDTH = WIDTH + 2,
    parameter int LANES     = 16,
    parameter int BLK_LEN   = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_valid,
    input  logic [1:0]                  i_mode,
    input  logic signed [WIDTH-1:0]     i_re [0:LANES-1],
    input  logic signed [WIDTH-1:0]     i_im [0:LANES-1],
    input  logic                        i_clr_sat,
    output logic                        o_valid,
    output logic                        o_last,
    output logic signed [OUT_WIDTH-1:0] o_re [0:LANES-1],
    output logic signed [OUT_WIDTH-1:0] o_im [0:LANES-1],
    output logic                        o_sat
);

    // Twiddles are Q2.8 and span -256..256, which needs 10 signed bits.
    localparam int TW = 10;
    localparam int PW = WIDTH + TW;
    // Sum width: one guard bit over the products, widened if the output is wider still.
    localparam int XW = (PW + 1 > OUT_WIDTH + 1) ? PW + 1 : OUT_WIDTH + 1;
    localparam int CW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

    localparam logic signed [XW-1:0] MAXV = {{(XW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    // ---------------- frame position and mode ----------------
    logic [CW-1:0] beat_cnt;
    logic [1:0]    frame_mode;
    logic          is_first;
    logic          is_last;
    logic [1:0]    beat_mode;

    assign is_first  = (beat_cnt == '0);
    assign is_last   = (beat_cnt == CW'(BLK_LEN - 1));
    // The frame-start beat uses the live i_mode; later beats reuse the value latched then.
    assign beat_mode = is_first ? i_mode : frame_mode;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt   <= '0;
            frame_mode <= 2'd0;
        end else if (i_valid) begin
            beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;
            if (is_first) begin
                frame_mode <= i_mode;
            end
        end
    end

    // ---------------- twiddle selection ----------------
    logic signed [TW-1:0] tw_c [0:LANES-1];
    logic signed [TW-1:0] tw_d [0:LANES-1];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            tw_c[l] = 10'sd256;
            tw_d[l] = 10'sd0;
            if (beat_mode == 2'd1 || beat_mode == 2'd2) begin
                case (l % 8)
                    3: begin
                        tw_c[l] = 10'sd0;
                        tw_d[l] = -10'sd256;
                    end
                    5: begin
                        tw_c[l] = 10'sd181;
                        tw_d[l] = -10'sd181;
                    end
                    7: begin
                        tw_c[l] = -10'sd181;
                        tw_d[l] = -10'sd181;
                    end
                    default: begin
                        tw_c[l] = 10'sd256;
                        tw_d[l] = 10'sd0;
                    end
                endcase
                // Inverse set is the conjugate twiddle.
                if (beat_mode == 2'd2) begin
                    tw_d[l] = -tw_d[l];
                end
            end
        end
    end

    // ---------------- S1: samples and twiddles ----------------
    logic                    s1_vld;
    logic                    s1_last;
    logic signed [WIDTH-1:0] s1_a [0:LANES-1];
    logic signed [WIDTH-1:0] s1_b [0:LANES-1];
    logic signed [TW-1:0]    s1_c [0:LANES-1];
    logic signed [TW-1:0]    s1_d [0:LANES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                s1_a[l] <= '0;
                s1_b[l] <= '0;
                s1_c[l] <= '0;
                s1_d[l] <= '0;
            end
        end else begin
            s1_vld  <= i_valid;
            s1_last <= i_valid && is_last;
            for (int l = 0; l < LANES; l++) begin
                s1_a[l] <= i_valid ? i_re[l] : '0;
                s1_b[l] <= i_valid ? i_im[l] : '0;
                s1_c[l] <= i_valid ? tw_c[l] : '0;
                s1_d[l] <= i_valid ? tw_d[l] : '0;
            end
        end
    end

    // ---------------- S2: full-precision products ----------------
    logic                 s2_vld;
    logic                 s2_last;
    logic signed [PW-1:0] s2_ac [0:LANES-1];
    logic signed [PW-1:0] s2_bd [0:LANES-1];
    logic signed [PW-1:0] s2_ad [0:LANES-1];
    logic signed [PW-1:0] s2_bc [0:LANES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                s2_ac[l] <= '0;
                s2_bd[l] <= '0;
                s2_ad[l] <= '0;
                s2_bc[l] <= '0;
            end
        end else begin
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            for (int l = 0; l < LANES; l++) begin
                s2_ac[l] <= s1_vld ? PW'(s1_a[l] * s1_c[l]) : '0;
                s2_bd[l] <= s1_vld ? PW'(s1_b[l] * s1_d[l]) : '0;
                s2_ad[l] <= s1_vld ? PW'(s1_a[l] * s1_d[l]) : '0;
                s2_bc[l] <= s1_vld ? PW'(s1_b[l] * s1_c[l]) : '0;
            end
        end
    end

    // ---------------- S3: round half up, then saturate ----------------
    // Returns {saturated, value}.
    function automatic logic [OUT_WIDTH:0] rnd_sat(input logic signed [XW-1:0] full);
        logic signed [XW-1:0] r;
        r = (full + XW'(128)) >>> 8;
        if (r > MAXV) begin
            return {1'b1, MAXV[OUT_WIDTH-1:0]};
        end else if (r < MINV) begin
            return {1'b1, MINV[OUT_WIDTH-1:0]};
        end
        return {1'b0, r[OUT_WIDTH-1:0]};
    endfunction

    logic signed [OUT_WIDTH-1:0] res_re [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] res_im [0:LANES-1];
    logic                        sat_re [0:LANES-1];
    logic                        sat_im [0:LANES-1];
    logic                        sat_any;

    always_comb begin
        sat_any = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            {sat_re[l], res_re[l]} = rnd_sat(XW'(s2_ac[l]) - XW'(s2_bd[l]));
            {sat_im[l], res_im[l]} = rnd_sat(XW'(s2_ad[l]) + XW'(s2_bc[l]));
            sat_any = sat_any | sat_re[l] | sat_im[l];
        end
    end

    logic s3_sat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            s3_sat  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                o_re[l] <= '0;
                o_im[l] <= '0;
            end
        end else begin
            o_valid <= s2_vld;
            o_last  <= s2_vld && s2_last;
            s3_sat  <= s2_vld && sat_any;
            for (int l = 0; l < LANES; l++) begin
                o_re[l] <= s2_vld ? res_re[l] : '0;
                o_im[l] <= s2_vld ? res_im[l] : '0;
            end
        end
    end

    // Sticky flag follows the S3 write by one cycle; a new saturation beats a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_sat <= 1'b0;
        end else if (s3_sat) begin
            o_sat <= 1'b1;
        end else if (i_clr_sat) begin
            o_sat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_twd_mul_pipe.sv
module tb_twd_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              clr;
    logic signed [13:0] in_re [0:15];
    logic signed [13:0] in_im [0:15];

    // dut_a: default sizes, 4-beat frames
    logic              a_in_vld;
    logic [1:0]        a_mode;
    logic              a_vld, a_last, a_sat;
    logic signed [15:0] a_re [0:15];
    logic signed [15:0] a_im [0:15];

    // dut_b: output width equals input width, 1-beat frames
    logic              b_in_vld;
    logic [1:0]        b_mode;
    logic              b_vld, b_last, b_sat;
    logic signed [13:0] b_re [0:15];
    logic signed [13:0] b_im [0:15];

    twd_mul_pipe #(.WIDTH(14), .OUT_WIDTH(16), .LANES(16), .BLK_LEN(4)) dut_a (
        .clk(clk), .rstn(rstn), .i_valid(a_in_vld), .i_mode(a_mode),
        .i_re(in_re), .i_im(in_im), .i_clr_sat(clr),
        .o_valid(a_vld), .o_last(a_last), .o_re(a_re), .o_im(a_im), .o_sat(a_sat)
    );

    twd_mul_pipe #(.WIDTH(14), .OUT_WIDTH(14), .LANES(16), .BLK_LEN(1)) dut_b (
        .clk(clk), .rstn(rstn), .i_valid(b_in_vld), .i_mode(b_mode),
        .i_re(in_re), .i_im(in_im), .i_clr_sat(clr),
        .o_valid(b_vld), .o_last(b_last), .o_re(b_re), .o_im(b_im), .o_sat(b_sat)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        for (int l = 0; l < 16; l++) begin
            in_re[l] = 14'sd0;
            in_im[l] = 14'sd0;
        end
        a_in_vld = 1'b0;
        b_in_vld = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        int         lane;
        int         re;
        int         im;
        int         exp_re;
        int         exp_im;
    } vec_t;

    vec_t vt [10];

    // Watchdog: the sequence below is bounded, this only guards against a hung simulator.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] fmode [8];
        int         j;

        vt[0] = '{2'd1, 3,   100,    0,     0,  -100};
        vt[1] = '{2'd1, 5,   100,  100,   141,     0};
        vt[2] = '{2'd2, 5,   100,  100,     0,   141};
        vt[3] = '{2'd0, 0,    -1,    1,    -1,     1};
        vt[4] = '{2'd3, 5,   100,  100,   100,   100};
        vt[5] = '{2'd1, 1,   -50,    7,   -50,     7};
        vt[6] = '{2'd1, 7,   100,    0,   -71,   -71};
        vt[7] = '{2'd2, 3,     0,  100,  -100,     0};
        vt[8] = '{2'd1, 13,  100,  100,   141,     0};
        vt[9] = '{2'd0, 2, -8192, -8192, -8192, -8192};

        rstn   = 1'b0;
        clr    = 1'b0;
        a_mode = 2'd0;
        b_mode = 2'd0;
        idle_inputs();

        repeat (2) @(negedge clk);
        chk("reset a_valid", a_vld, 0);
        chk("reset a_last", a_last, 0);
        chk("reset a_sat", a_sat, 0);
        chk("reset a_re0", a_re[0], 0);
        chk("reset b_valid", b_vld, 0);
        chk("reset b_sat", b_sat, 0);
        rstn = 1'b1;
        @(negedge clk);

        // ---- table vectors on the 1-beat-frame instance ----
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            b_in_vld           = 1'b1;
            b_mode             = vt[i].mode;
            in_re[vt[i].lane]  = 14'(vt[i].re);
            in_im[vt[i].lane]  = 14'(vt[i].im);
            @(negedge clk);
            idle_inputs();
            @(negedge clk);
            chk($sformatf("vec%0d early valid", i), b_vld, 0);
            chk($sformatf("vec%0d idle re", i), b_re[vt[i].lane], 0);
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), b_vld, 1);
            chk($sformatf("vec%0d last", i), b_last, 1);
            chk($sformatf("vec%0d re", i), b_re[vt[i].lane], vt[i].exp_re);
            chk($sformatf("vec%0d im", i), b_im[vt[i].lane], vt[i].exp_im);
        end
        @(negedge clk);
        chk("no sat after table", b_sat, 0);

        // ---- positive saturation, sticky flag, clear ----
        idle_inputs();
        b_in_vld  = 1'b1;
        b_mode    = 2'd1;
        in_re[5]  = 14'sd8191;
        in_im[5]  = 14'sd8191;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("possat valid", b_vld, 1);
        chk("possat re", b_re[5], 8191);
        chk("possat im", b_im[5], 0);
        chk("possat flag not yet", b_sat, 0);
        @(negedge clk);
        chk("possat flag set", b_sat, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("sat cleared", b_sat, 0);

        // ---- negative saturation with clear on the same edge as the set ----
        b_in_vld  = 1'b1;
        b_mode    = 2'd1;
        in_re[5]  = -14'sd8192;
        in_im[5]  = -14'sd8192;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("negsat re", b_re[5], -8192);
        chk("negsat im", b_im[5], 0);
        chk("negsat flag not yet", b_sat, 0);
        clr = 1'b1;
        @(negedge clk);
        chk("set wins over clear", b_sat, 1);
        @(negedge clk);
        chk("clear after set", b_sat, 0);
        clr = 1'b0;
        @(negedge clk);

        // ---- 8 back-to-back beats, mode changes mid-frame ignored ----
        fmode = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0};
        for (int i = 0; i < 12; i++) begin
            if (i >= 3 && i < 11) begin
                j = i - 3;
                chk($sformatf("b2b%0d valid", j), a_vld, 1);
                chk($sformatf("b2b%0d last", j), a_last, (j % 4 == 3) ? 1 : 0);
                chk($sformatf("b2b%0d lane0 re", j), a_re[0], j + 1);
                chk($sformatf("b2b%0d lane3 re", j), a_re[3], (j < 4) ? 0 : 100);
                chk($sformatf("b2b%0d lane3 im", j), a_im[3], (j < 4) ? -100 : 0);
            end
            if (i == 11) begin
                chk("b2b drained valid", a_vld, 0);
                chk("b2b drained re", a_re[0], 0);
            end
            idle_inputs();
            if (i < 8) begin
                a_in_vld = 1'b1;
                a_mode   = fmode[i];
                in_re[0] = 14'(i + 1);
                in_re[3] = 14'sd100;
            end
            @(negedge clk);
        end

        // ---- reset with two beats in flight ----
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            a_in_vld = 1'b1;
            a_mode   = 2'd1;
            in_re[3] = 14'sd100;
            @(negedge clk);
        end
        idle_inputs();
        rstn = 1'b0;
        #1;
        chk("in-reset valid", a_vld, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("flushed%0d valid", k), a_vld, 0);
            @(negedge clk);
        end
        fmode = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 8; i++) begin
            if (i >= 3 && i < 7) begin
                j = i - 3;
                chk($sformatf("post%0d valid", j), a_vld, 1);
                chk($sformatf("post%0d last", j), a_last, (j == 3) ? 1 : 0);
                chk($sformatf("post%0d lane3 re", j), a_re[3], 0);
                chk($sformatf("post%0d lane3 im", j), a_im[3], -100);
            end
            if (i == 7) begin
                chk("post drained valid", a_vld, 0);
            end
            idle_inputs();
            if (i < 4) begin
                a_in_vld = 1'b1;
                a_mode   = fmode[i];
                in_re[3] = 14'sd100;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
